// File: rtl/sram_bus_pkg.sv
// Shared types and helpers for the 64-bit SRAM bus initiator.
// Byte addresses map to a 17-bit line address and a half select.
package sram_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int SRAM_ADDR_W = 17;
    localparam int SRAM_DATA_W = 64;
    localparam int WORD_W      = 32;

    typedef struct packed {
        logic [SRAM_ADDR_W-1:0] line;
        logic                   half;
    } bus_loc_t;

    // Offset from the base in 32-bit modulo arithmetic; bits [19:2] give {line, half}.
    function automatic bus_loc_t map_addr(input logic [31:0] addr, input logic [31:0] base);
        return bus_loc_t'(18'((addr - base) >> 2));
    endfunction

    // Pick the 32-bit word of a line addressed by half.
    function automatic logic [WORD_W-1:0] sel_half(input logic [SRAM_DATA_W-1:0] line,
                                                   input logic                   half);
        return half ? line[63:32] : line[31:0];
    endfunction

    // Replace the addressed half of a line with a new word.
    function automatic logic [SRAM_DATA_W-1:0] merge_half(input logic [SRAM_DATA_W-1:0] line,
                                                          input logic                   half,
                                                          input logic [WORD_W-1:0]      word);
        return half ? {word, line[31:0]} : {line[63:32], word};
    endfunction

endpackage

// File: rtl/sram_line_buf.sv
// One-entry line buffer (valid, tag, data) in front of the SRAM bus.
// Storage exists only when SRAM_LINE_BUF_EN is defined; otherwise it never hits.
module sram_line_buf
    import sram_bus_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [SRAM_ADDR_W-1:0] lookup_tag,
    output logic                   hit,
    output logic [SRAM_DATA_W-1:0] hit_data,
    input  logic                   wr_en,
    input  logic [SRAM_ADDR_W-1:0] wr_tag,
    input  logic [SRAM_DATA_W-1:0] wr_data
);

`ifdef SRAM_LINE_BUF_EN
    logic                   valid_r;
    logic [SRAM_ADDR_W-1:0] tag_r;
    logic [SRAM_DATA_W-1:0] data_r;

    // Capture a fresh or merged line whenever the sequencer writes the entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r <= 1'b0;
            tag_r   <= {SRAM_ADDR_W{1'b0}};
            data_r  <= {SRAM_DATA_W{1'b0}};
        end else if (wr_en) begin
            valid_r <= 1'b1;
            tag_r   <= wr_tag;
            data_r  <= wr_data;
        end else begin
            valid_r <= valid_r;
            tag_r   <= tag_r;
            data_r  <= data_r;
        end
    end

    assign hit      = valid_r && (tag_r == lookup_tag);
    assign hit_data = data_r;
`else
    logic unused_s;

    assign unused_s = ^{clk, reset, lookup_tag, wr_en, wr_tag, wr_data};
    assign hit      = 1'b0;
    assign hit_data = {SRAM_DATA_W{1'b0}};
`endif

endmodule

// File: rtl/sram_bus_master.sv
// Memory-stage initiator for the 64-bit SRAM bus: 32-bit loads are timed
// reads, 32-bit stores are read-modify-write (the bus has no byte enables).
// Optional one-entry line buffer: define SRAM_LINE_BUF_EN.
module sram_bus_master
    import sram_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WAIT_CYCLES = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [WORD_W-1:0]      st_val,
    output logic [WORD_W-1:0]      rd_data,
    output logic                   ready,
    output logic                   SRAM_WE_N,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ
);

    localparam int                CNT_W      = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    state_e                 state_r, state_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s;
    logic                   op_wr_r, op_wr_s;
    logic [SRAM_ADDR_W-1:0] line_addr_r, line_addr_s;
    logic                   half_r, half_s;
    logic [WORD_W-1:0]      st_val_r, st_val_s;
    logic [SRAM_DATA_W-1:0] line_r, line_s;
    logic [WORD_W-1:0]      rd_data_r, rd_data_s;
    logic                   ready_r, ready_s;
    logic                   we_n_r, we_n_s;
    logic                   dq_oe_r, dq_oe_s;

    bus_loc_t               loc_s;
    logic [SRAM_DATA_W-1:0] merged_s;
    logic                   buf_hit_s;
    logic [SRAM_DATA_W-1:0] buf_data_s;
    logic                   buf_wr_s;
    logic [SRAM_DATA_W-1:0] buf_wdata_s;

    assign loc_s = map_addr(address, BASE_ADDR);

    sram_line_buf u_line_buf (
        .clk        (clk),
        .reset      (reset),
        .lookup_tag (loc_s.line),
        .hit        (buf_hit_s),
        .hit_data   (buf_data_s),
        .wr_en      (buf_wr_s),
        .wr_tag     (line_addr_s),
        .wr_data    (buf_wdata_s)
    );

    // Merged store line: from the buffer on an IDLE hit, otherwise from the bus sample.
    always_comb begin
        merged_s = {SRAM_DATA_W{1'b0}};
        if (state_r == IDLE) begin
            merged_s = merge_half(buf_data_s, loc_s.half, st_val);
        end else begin
            merged_s = merge_half(SRAM_DQ, half_r, st_val_r);
        end
    end

    // Next-state and next-value logic for the access sequencer.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        op_wr_s     = op_wr_r;
        line_addr_s = line_addr_r;
        half_s      = half_r;
        st_val_s    = st_val_r;
        line_s      = line_r;
        rd_data_s   = rd_data_r;
        ready_s     = 1'b0;
        we_n_s      = 1'b1;
        dq_oe_s     = 1'b0;
        buf_wr_s    = 1'b0;
        buf_wdata_s = merged_s;
        case (state_r)
            IDLE: begin
                if (rd_en || wr_en) begin
                    // wr_en wins when both are asserted; inputs are frozen from here on
                    op_wr_s     = wr_en;
                    line_addr_s = loc_s.line;
                    half_s      = loc_s.half;
                    st_val_s    = st_val;
                    cnt_s       = CNT_RELOAD;
                    if (buf_hit_s && wr_en) begin
                        line_s   = merged_s;
                        buf_wr_s = 1'b1;
                        we_n_s   = 1'b0;
                        dq_oe_s  = 1'b1;
                        state_s  = WR;
                    end else if (buf_hit_s) begin
                        rd_data_s = sel_half(buf_data_s, loc_s.half);
                        ready_s   = 1'b1;
                        state_s   = DONE;
                    end else begin
                        state_s = RD;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RD: begin
                if (cnt_r == CNT_ZERO) begin
                    buf_wr_s = 1'b1;
                    if (op_wr_r) begin
                        // WE_N falls on this edge only, together with the DQ enable
                        line_s  = merged_s;
                        we_n_s  = 1'b0;
                        dq_oe_s = 1'b1;
                        cnt_s   = CNT_RELOAD;
                        state_s = WR;
                    end else begin
                        line_s      = SRAM_DQ;
                        buf_wdata_s = SRAM_DQ;
                        rd_data_s   = sel_half(SRAM_DQ, half_r);
                        ready_s     = 1'b1;
                        state_s     = DONE;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            WR: begin
                if (cnt_r == CNT_ZERO) begin
                    ready_s = 1'b1;
                    state_s = DONE;
                end else begin
                    cnt_s   = cnt_r - CNT_ONE;
                    we_n_s  = 1'b0;
                    dq_oe_s = 1'b1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and bus-facing registers; reset floats DQ and raises WE_N at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r       <= CNT_ZERO;
            op_wr_r     <= 1'b0;
            line_addr_r <= {SRAM_ADDR_W{1'b0}};
            half_r      <= 1'b0;
            st_val_r    <= {WORD_W{1'b0}};
            line_r      <= {SRAM_DATA_W{1'b0}};
            rd_data_r   <= {WORD_W{1'b0}};
            ready_r     <= 1'b0;
            we_n_r      <= 1'b1;
            dq_oe_r     <= 1'b0;
        end else begin
            cnt_r       <= cnt_s;
            op_wr_r     <= op_wr_s;
            line_addr_r <= line_addr_s;
            half_r      <= half_s;
            st_val_r    <= st_val_s;
            line_r      <= line_s;
            rd_data_r   <= rd_data_s;
            ready_r     <= ready_s;
            we_n_r      <= we_n_s;
            dq_oe_r     <= dq_oe_s;
        end
    end

    assign rd_data   = rd_data_r;
    assign ready     = ready_r;
    assign SRAM_WE_N = we_n_r;
    assign SRAM_ADDR = line_addr_r;
    assign SRAM_DQ   = dq_oe_r ? line_r : {SRAM_DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_bus_master.sv
// Self-checking bench for sram_bus_master with a small SRAM model on the bus.
// Expected results are pushed to a scoreboard queue when each request is
// driven and popped when ready is seen.
module tb_sram_bus_master;

    localparam int          W    = 5;
    localparam logic [31:0] BASE = 32'd1024;
`ifdef SRAM_LINE_BUF_EN
    localparam bit          BUF_EN = 1'b1;
`else
    localparam bit          BUF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_en, wr_en;
    logic [31:0] address, st_val;
    logic [31:0] rd_data;
    logic        ready;
    logic        sram_we_n;
    logic [16:0] sram_addr;
    wire  [63:0] sram_dq;

    always #5 clk = ~clk;

    sram_bus_master #(.BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .address   (address),
        .st_val    (st_val),
        .rd_data   (rd_data),
        .ready     (ready),
        .SRAM_WE_N (sram_we_n),
        .SRAM_ADDR (sram_addr),
        .SRAM_DQ   (sram_dq)
    );

    // SRAM model: 32 lines (aliased on addr[4:0]), drives DQ whenever WE_N is high.
    logic [63:0] mem [0:31];
    logic        pre_en = 1'b0;
    logic [4:0]  pre_idx = 5'd0;
    logic [63:0] pre_val = 64'd0;

    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_val;
        else if (!sram_we_n) mem[sram_addr[4:0]] <= sram_dq;
    end

    assign sram_dq = sram_we_n ? mem[sram_addr[4:0]] : 64'bz;

    // Bench reference state
    logic [63:0] refm [0:31];
    logic [31:0] last_rd;
    logic        mvalid;
    logic [16:0] mtag;

    typedef struct {
        logic        is_wr;
        logic [16:0] line;
        logic [31:0] data;
        int          lat;
        int          wcyc;
        logic [63:0] wdq;
    } exp_t;

    exp_t sb_q[$];

    int checks_cnt = 0;
    int fail_cnt   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [4:0] idx, input logic [63:0] val);
        pre_idx = idx;
        pre_val = val;
        pre_en  = 1'b1;
        @(posedge clk); #1;
        pre_en  = 1'b0;
        refm[idx] = val;
    endtask

    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] sv, input logic chg, input logic [31:0] chg_addr);
        exp_t        e;
        logic [31:0] off;
        logic [16:0] ln;
        logic        h;
        logic        hit;
        logic [63:0] old;
        logic [63:0] seen_dq;
        int          n;
        int          wc;
        logic        got;

        off = addr - BASE;
        ln  = off[19:3];
        h   = off[2];
        old = refm[ln[4:0]];
        hit = BUF_EN && mvalid && (mtag == ln);

        e.is_wr = wr;
        e.line  = ln;
        e.wdq   = h ? {sv, old[31:0]} : {old[63:32], sv};
        e.data  = wr ? last_rd : (h ? old[63:32] : old[31:0]);
        e.lat   = wr ? (hit ? W + 1 : 2 * W + 1) : (hit ? 1 : W + 1);
        e.wcyc  = wr ? W : 0;
        sb_q.push_back(e);

        if (wr) refm[ln[4:0]] = e.wdq;
        last_rd = e.data;
        mvalid  = 1'b1;
        mtag    = ln;

        rd_en   = rd;
        wr_en   = wr;
        address = addr;
        st_val  = sv;

        n = 0; wc = 0; got = 1'b0; seen_dq = 64'd0;
        while (!got && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (!sram_we_n) begin
                wc++;
                seen_dq = sram_dq;
            end
            if (chg && n == 2) address = chg_addr;
            if (n == 3 && e.lat > 3) check_eq("sram_addr", 64'(sram_addr), 64'(ln));
            if (ready) got = 1'b1;
        end
        check_eq("ready_timeout", 64'(got), 64'd1);

        e = sb_q.pop_front();
        check_eq("latency", 64'(n), 64'(e.lat));
        check_eq(e.is_wr ? "rd_data_kept" : "rd_data", 64'(rd_data), 64'(e.data));
        check_eq("we_low_cycles", 64'(wc), 64'(e.wcyc));
        if (e.is_wr) check_eq("wr_dq", seen_dq, e.wdq);

        rd_en = 1'b0;
        wr_en = 1'b0;
        @(posedge clk); #1;
        check_eq("ready_pulse", 64'(ready), 64'd0);
    endtask

    initial begin
        logic [4:0] ix;
        reset   = 1'b0;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        address = 32'd0;
        st_val  = 32'd0;
        last_rd = 32'd0;
        mvalid  = 1'b0;
        mtag    = 17'd0;

        for (int i = 0; i < 32; i++) begin
            ix = 5'(i);
            preload(ix, {16'hC0DE, 11'h0, ix, 16'hF00D, 11'h0, ix});
        end
        preload(5'd0, 64'h1111_2222_3333_4444);
        preload(5'd1, 64'h5555_6666_7777_8888);
        preload(5'd2, 64'h2222_0000_2222_1111);
        preload(5'd3, 64'hAAAA_BBBB_CCCC_DDDD);
        preload(5'd5, 64'h5050_5050_A5A5_A5A5);

        // Reset state
        check_eq("rst_ready", 64'(ready), 64'd0);
        check_eq("rst_rd_data", 64'(rd_data), 64'd0);
        check_eq("rst_we_n", 64'(sram_we_n), 64'd1);
        check_eq("rst_sram_addr", 64'(sram_addr), 64'd0);

        reset = 1'b1;
        @(posedge clk); #1;

        // Loads from line 0, both halves
        access(1'b1, 1'b0, BASE,      32'd0, 1'b0, 32'd0);
        access(1'b1, 1'b0, BASE + 4,  32'd0, 1'b0, 32'd0);
        // Store RMW into upper half of line 3, then read it back
        access(1'b0, 1'b1, BASE + 28, 32'h0BAD_F00D, 1'b0, 32'd0);
        check_eq("mem_line3", mem[3], 64'h0BAD_F00D_CCCC_DDDD);
        access(1'b1, 1'b0, BASE + 28, 32'd0, 1'b0, 32'd0);
        // Both enables: store wins, rd_data untouched
        access(1'b1, 1'b1, BASE + 8,  32'hDEAD_BEEF, 1'b0, 32'd0);
        check_eq("mem_line1", mem[1], 64'h5555_6666_DEAD_BEEF);
        // Address changed mid-RD must not move the bus address
        access(1'b1, 1'b0, BASE + 16, 32'd0, 1'b1, BASE + 40);
        // Wrap above and below the base
        access(1'b1, 1'b0, BASE + 32'h0010_0000, 32'd0, 1'b0, 32'd0);
        access(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        check_eq("below_base_addr", 64'(sram_addr), 64'h1FF80);

        // Reset in the second WR cycle of a store to line 6
        rd_en   = 1'b0;
        wr_en   = 1'b1;
        address = BASE + 48;
        st_val  = 32'h1234_5678;
        repeat (W + 2) begin
            @(posedge clk); #1;
        end
        check_eq("we_n_in_wr", 64'(sram_we_n), 64'd0);
        reset = 1'b0;
        #1;
        check_eq("abort_we_n", 64'(sram_we_n), 64'd1);
        check_eq("abort_ready", 64'(ready), 64'd0);
        check_eq("abort_dq_model", sram_dq, refm[0]);
        refm[6] = {refm[6][63:32], 32'h1234_5678};
        wr_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("post_rst_ready", 64'(ready), 64'd0);
        check_eq("post_rst_we_n", 64'(sram_we_n), 64'd1);
        check_eq("post_rst_rd_data", 64'(rd_data), 64'd0);
        last_rd = 32'd0;
        mvalid  = 1'b0;

        // Normal operation after the abort; store then load the same line
        access(1'b1, 1'b0, BASE + 4, 32'd0, 1'b0, 32'd0);
        access(1'b0, 1'b1, BASE,     32'hCAFE_0001, 1'b0, 32'd0);
        access(1'b1, 1'b0, BASE,     32'd0, 1'b0, 32'd0);
        check_eq("mem_line0", mem[0], 64'h1111_2222_CAFE_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
